// File: rtl/fifo_traffic_pkg.sv
// rtl/fifo_traffic_pkg.sv - shared opcodes, state encoding and defaults for the FIFO traffic master
package fifo_traffic_pkg;

    // Default geometry of the FIFO opcode interface
    localparam int DATA_W_DEF  = 32;
    localparam int CNT_W_DEF   = 5;
    localparam int TIMEOUT_DEF = 64;

    // FIFO command opcodes, shared with the FIFO itself
    localparam logic [1:0] OP_IDLE  = 2'b00;
    localparam logic [1:0] OP_WRITE = 2'b01;
    localparam logic [1:0] OP_READ  = 2'b10;

    // Burst sequencer states
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_FILL  = 3'd1,
        ST_DRAIN = 3'd2,
        ST_FLUSH = 3'd3,
        ST_FIN   = 3'd4
    } state_t;

    // States in which the master may issue FIFO transfers
    function automatic logic is_xfer_state(input state_t s);
        return (s == ST_FILL) || (s == ST_DRAIN);
    endfunction

endpackage

// File: rtl/fifo_rd_checker.sv
// rtl/fifo_rd_checker.sv - one-cycle-delayed compare of FIFO read data with a saturating error count
module fifo_rd_checker
    import fifo_traffic_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int CNT_W  = CNT_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              rd_edge,
    input  logic [DATA_W-1:0] exp_word,
    input  logic [DATA_W-1:0] dout,
    input  logic              clr_err,
    output logic              rd_pend,
    output logic [CNT_W-1:0]  err_count
);

    logic [DATA_W-1:0] exp_reg;
    logic              mismatch;

    assign mismatch = rd_pend && (dout != exp_reg);

    // Capture the expected word on a read edge; compare it against Dout one cycle later
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_pend   <= 1'b0;
            exp_reg   <= '0;
            err_count <= '0;
        end else begin
            rd_pend <= rd_edge;
            if (rd_edge) begin
                exp_reg <= exp_word;
            end
            if (clr_err) begin
                err_count <= '0;
            end else if (mismatch && (err_count != {CNT_W{1'b1}})) begin
                err_count <= err_count + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/fifo_traffic_master.sv
// rtl/fifo_traffic_master.sv - burst fill/drain initiator for the 16-entry FIFO opcode interface
module fifo_traffic_master
    import fifo_traffic_pkg::*;
#(
    parameter int DATA_W  = DATA_W_DEF,
    parameter int CNT_W   = CNT_W_DEF,
    parameter int TIMEOUT = TIMEOUT_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              dir,
    input  logic [CNT_W-1:0]  count,
    input  logic [DATA_W-1:0] seed,
    output logic              busy,
    output logic              done,
    output logic              timeout,
    output logic [CNT_W-1:0]  err_count,
    output logic              proto_err,
    output logic [1:0]        opcode,
    output logic [DATA_W-1:0] din,
    input  logic [DATA_W-1:0] dout,
    input  logic              fifo_full,
    input  logic              fifo_empty,
    input  logic              overflow,
    input  logic              underflow
);

    localparam int STALL_W = $clog2(TIMEOUT + 1);

    state_t             state;
    state_t             nstate;
    logic [CNT_W-1:0]   remaining;
    logic [DATA_W-1:0]  pattern;
    logic [STALL_W-1:0] stall_cnt;

    logic accept;
    logic xfer;
    logic blocked;
    logic stall_hit;
    logic rd_edge;
    logic rd_pend;

    // A start strobe only counts while idle
    assign accept    = (state == ST_IDLE) && start;
    assign xfer      = (opcode != OP_IDLE);
    assign blocked   = is_xfer_state(state) && (remaining != '0) && !xfer;
    assign stall_hit = blocked && (stall_cnt == STALL_W'(TIMEOUT - 1));
    assign rd_edge   = (opcode == OP_READ);

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= nstate;
        end
    end

    // Next-state: bursts end on exhaustion or stall timeout; drains get a flush cycle for the last compare
    always_comb begin
        nstate = state;
        case (state)
            ST_IDLE: begin
                if (accept) begin
                    if (count == '0) begin
                        nstate = ST_FIN;
                    end else if (dir) begin
                        nstate = ST_DRAIN;
                    end else begin
                        nstate = ST_FILL;
                    end
                end
            end
            ST_FILL: begin
                if ((remaining == '0) || stall_hit) begin
                    nstate = ST_FIN;
                end
            end
            ST_DRAIN: begin
                if (remaining == '0) begin
                    nstate = ST_FLUSH;
                end else if (stall_hit) begin
                    nstate = rd_pend ? ST_FLUSH : ST_FIN;
                end
            end
            ST_FLUSH: nstate = ST_FIN;
            ST_FIN:   nstate = ST_IDLE;
            default:  nstate = ST_IDLE;
        endcase
    end

    // Outputs: opcode gated by FIFO flags so the FIFO can never overflow or underflow
    always_comb begin
        opcode = OP_IDLE;
        din    = '0;
        busy   = (state != ST_IDLE);
        done   = (state == ST_FIN);
        if ((state == ST_FILL) && (remaining != '0) && !fifo_full) begin
            opcode = OP_WRITE;
        end else if ((state == ST_DRAIN) && (remaining != '0) && !fifo_empty) begin
            opcode = OP_READ;
        end
        if (state == ST_FILL) begin
            din = pattern;
        end
    end

    // Burst bookkeeping: remaining count, pattern generator, stall counter and timeout flag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            remaining <= '0;
            pattern   <= '0;
            stall_cnt <= '0;
            timeout   <= 1'b0;
        end else if (accept) begin
            remaining <= count;
            pattern   <= seed;
            stall_cnt <= '0;
            timeout   <= 1'b0;
        end else if (xfer) begin
            remaining <= remaining - CNT_W'(1);
            pattern   <= pattern + DATA_W'(1);
            stall_cnt <= '0;
        end else if (blocked) begin
            stall_cnt <= stall_cnt + STALL_W'(1);
            if (stall_hit) begin
                timeout <= 1'b1;
            end
        end
    end

    // Sticky protocol error: any FIFO overflow/underflow pulse, in any state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            proto_err <= 1'b0;
        end else if (overflow || underflow) begin
            proto_err <= 1'b1;
        end
    end

    fifo_rd_checker #(
        .DATA_W (DATA_W),
        .CNT_W  (CNT_W)
    ) u_rd_checker (
        .clk       (clk),
        .rst_n     (rst_n),
        .rd_edge   (rd_edge),
        .exp_word  (pattern),
        .dout      (dout),
        .clr_err   (accept),
        .rd_pend   (rd_pend),
        .err_count (err_count)
    );

endmodule

// File: tb/tb_fifo_traffic_master.sv
// tb/tb_fifo_traffic_master.sv - self-checking bench with a queue-based FIFO and burst reference model
module tb_fifo_traffic_master;

    localparam int DW = 32;
    localparam int CW = 5;
    localparam int TO = 8;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start;
    logic          dir;
    logic [CW-1:0] count;
    logic [DW-1:0] seed;
    logic          busy;
    logic          done;
    logic          timeout;
    logic [CW-1:0] err_count;
    logic          proto_err;
    logic [1:0]    opcode;
    logic [DW-1:0] din;
    logic [DW-1:0] dout = '0;
    logic          fifo_full;
    logic          fifo_empty;
    logic          overflow;
    logic          underflow;

    logic [DW-1:0] fq[$];
    int            fcnt  = 0;
    logic          ovf_r = 1'b0;
    logic          unf_r = 1'b0;
    logic          inj_ovf;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    fifo_traffic_master #(
        .DATA_W  (DW),
        .CNT_W   (CW),
        .TIMEOUT (TO)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .dir        (dir),
        .count      (count),
        .seed       (seed),
        .busy       (busy),
        .done       (done),
        .timeout    (timeout),
        .err_count  (err_count),
        .proto_err  (proto_err),
        .opcode     (opcode),
        .din        (din),
        .dout       (dout),
        .fifo_full  (fifo_full),
        .fifo_empty (fifo_empty),
        .overflow   (overflow),
        .underflow  (underflow)
    );

    // Behavioural 16-entry FIFO: full flag at 15 entries, read data registered
    always @(posedge clk) begin
        ovf_r <= 1'b0;
        unf_r <= 1'b0;
        if (opcode == 2'b01) begin
            if (fq.size() >= 16) ovf_r <= 1'b1;
            else fq.push_back(din);
        end else if (opcode == 2'b10) begin
            if (fq.size() == 0) unf_r <= 1'b1;
            else dout <= fq.pop_front();
        end
        fcnt <= fq.size();
    end

    assign fifo_full  = (fcnt >= 15);
    assign fifo_empty = (fcnt == 0);
    assign overflow   = ovf_r | inj_ovf;
    assign underflow  = unf_r;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One burst: expectations come from the FIFO contents and the burst rules, not from the DUT
    task automatic run_burst(input logic d, input int cnt, input logic [DW-1:0] sd, input string tag);
        logic [DW-1:0] snap[$];
        logic [DW-1:0] want;
        int n, exp_err, exp_done, exp_size, nx, bad, cyc, done_cyc;
        bit exp_to;
        snap = fq;
        if (d == 1'b0) n = (cnt < 15 - snap.size()) ? cnt : ((15 - snap.size()) > 0 ? 15 - snap.size() : 0);
        else           n = (cnt < snap.size()) ? cnt : snap.size();
        exp_to  = (n < cnt);
        exp_err = 0;
        if (d) begin
            for (int i = 0; i < n; i++) begin
                want = sd + DW'(i);
                if (snap[i] !== want) exp_err++;
            end
            if (exp_err > 31) exp_err = 31;
        end
        exp_done = (cnt == 0) ? 0 : (exp_to ? n + TO : (d ? n + 2 : n + 1));
        exp_size = d ? snap.size() - n : snap.size() + n;

        start = 1'b1; dir = d; count = CW'(cnt); seed = sd;
        @(negedge clk);
        start = 1'b0;
        nx = 0; bad = 0; cyc = 0; done_cyc = -1;
        while (cyc < 300) begin
            if (done) begin
                done_cyc = cyc;
                break;
            end
            if (busy !== 1'b1) bad++;
            if (opcode == 2'b01) begin
                want = sd + DW'(nx);
                if (d || din !== want) bad++;
                nx++;
            end else if (opcode == 2'b10) begin
                if (!d) bad++;
                nx++;
            end else if (opcode !== 2'b00) begin
                bad++;
            end
            start = 1'($urandom_range(0, 1));
            dir   = 1'($urandom);
            count = CW'($urandom);
            seed  = $urandom;
            @(negedge clk);
            cyc++;
        end
        start = 1'b0;
        check({tag, " done_cycle"}, done_cyc, exp_done);
        check({tag, " transfers"}, nx, n);
        check({tag, " bad_cycles"}, bad, 0);
        check({tag, " busy_at_done"}, busy, 1'b1);
        check({tag, " timeout"}, timeout, exp_to);
        check({tag, " err_count"}, err_count, exp_err);
        check({tag, " proto_err"}, proto_err, 1'b0);
        @(negedge clk);
        check({tag, " done_pulse_width"}, {busy, done}, 2'b00);
        check({tag, " fifo_level"}, fq.size(), exp_size);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [DW-1:0] sd;
        int d, c;
        rst_n = 1'b0; start = 1'b0; dir = 1'b0; count = '0; seed = '0; inj_ovf = 1'b0;
        repeat (3) @(negedge clk);
        check("reset outputs", {busy, done, timeout, err_count, proto_err, opcode}, '0);
        check("reset din", din, '0);
        rst_n = 1'b1;
        @(negedge clk);
        check("idle after reset", {busy, done, opcode}, '0);

        run_burst(1'b0, 4, 32'h10, "fill4");
        run_burst(1'b1, 4, 32'h10, "drain4");
        check("drain4 fifo_empty", fifo_empty, 1'b1);
        run_burst(1'b0, 4, 32'h10, "fill4b");
        run_burst(1'b1, 4, 32'h11, "drain4_bad");
        check("drain4_bad err", err_count, 5'd4);
        run_burst(1'b0, 16, 32'h200, "fill16_to");
        check("fill16 timeout", timeout, 1'b1);
        run_burst(1'b1, 16, 32'h200, "drain16_to");
        run_burst(1'b0, 2, 32'hFFFF_FFFF, "fill_wrap");
        run_burst(1'b1, 2, 32'hFFFF_FFFF, "drain_wrap");
        run_burst(1'b0, 0, 32'h55, "fill_zero");

        for (int k = 0; k < 24; k++) begin
            d = $urandom_range(0, 1);
            c = $urandom_range(0, 16);
            if ($urandom_range(0, 3) == 0) sd = 32'hFFFF_FFF0 + 32'($urandom_range(0, 15));
            else sd = $urandom;
            if (d == 1 && fq.size() > 0 && $urandom_range(0, 2) != 0) sd = fq[0];
            run_burst(1'(d), c, sd, $sformatf("rand%0d", k));
        end

        while (fq.size() > 0) run_burst(1'b1, fq.size(), fq[0], "empty_out");

        start = 1'b1; dir = 1'b0; count = 5'd8; seed = 32'h100;
        @(negedge clk);
        start = 1'b0;
        repeat (5) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("async reset busy", busy, 1'b0);
        check("async reset opcode", opcode, 2'b00);
        check("async reset din", din, '0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("fifo after reset", fq.size(), 5);
        run_burst(1'b1, 5, 32'h100, "post_reset_drain");
        run_burst(1'b0, 3, 32'h7, "post_reset_fill");

        inj_ovf = 1'b1;
        @(negedge clk);
        inj_ovf = 1'b0;
        check("proto_err set", proto_err, 1'b1);
        repeat (3) @(negedge clk);
        check("proto_err sticky", proto_err, 1'b1);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check("proto_err cleared", proto_err, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
